// File: rtl/layers_frame_arbiter_fifo.sv
// layers_frame_arbiter_fifo
// Frame-granular merge of LAYER_COUNT AXI-Stream inputs into one buffered
// output stream. Frames are never interleaved. Arbitration is round-robin or
// fixed-priority, enables are per layer, and frames longer than
// MAX_FRAME_BEATS are truncated: the last stored beat is marked tlast and the
// rest of the frame is discarded. A first-word-fall-through FIFO buffers the
// output and reports its occupancy.
//
// Optional feature macro: LAYERS_FRAME_TAG_EN. When it is defined, every
// frame is preceded by one header beat that holds (layer index + 1).
//
// Ports:
//   clk_core, clk_core_resn         single clock, async active-low reset
//   s_axis_tdata/tvalid/tlast/tready per-layer input streams
//   cfg_layer_enable                per-layer grant enable, sampled in IDLE
//   cfg_fixed_priority              0 = round-robin, 1 = lowest index wins
//   m_axis_tdata/tvalid/tlast/tready buffered output stream
//   data_count                      FIFO occupancy, zero-extended to 32 bits
//   status_grant                    one-hot grant, 0 when idle
//   stat_frame_truncated            one-cycle pulse per truncated frame
module layers_frame_arbiter_fifo #(
  parameter int unsigned LAYER_COUNT     = 5,
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned FIFO_DEPTH      = 1024,
  parameter int unsigned MAX_FRAME_BEATS = 64
) (
  input  logic                              clk_core,
  input  logic                              clk_core_resn,
  input  logic [LAYER_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [LAYER_COUNT-1:0]            s_axis_tvalid,
  input  logic [LAYER_COUNT-1:0]            s_axis_tlast,
  output logic [LAYER_COUNT-1:0]            s_axis_tready,
  input  logic [LAYER_COUNT-1:0]            cfg_layer_enable,
  input  logic                              cfg_fixed_priority,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic [31:0]                       data_count,
  output logic [LAYER_COUNT-1:0]            status_grant,
  output logic                              stat_frame_truncated
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W   = AW + 1;
  localparam int unsigned IDX_W   = (LAYER_COUNT > 1) ? $clog2(LAYER_COUNT) : 1;
  localparam int unsigned BEAT_W  = $clog2(MAX_FRAME_BEATS);
  localparam int unsigned ENTRY_W = DATA_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FORWARD,
    ST_DRAIN
`ifdef LAYERS_FRAME_TAG_EN
    , ST_HEADER
`endif
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     rr_start;   // first index searched by round-robin
  logic [BEAT_W-1:0]    beat_cnt;   // payload beats accepted in this frame
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     count;
  logic [ENTRY_W-1:0]   mem [FIFO_DEPTH];

  logic [LAYER_COUNT-1:0] req;
  logic                   arb_hit;
  logic [IDX_W-1:0]       arb_idx;
  logic                   sel_valid;
  logic                   sel_last;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic                   full;
  logic                   fwd_acc;
  logic                   drain_acc;
  logic                   at_limit;
  logic                   trunc_c;
  logic                   wr_en;
  logic                   rd_en;
  logic [ENTRY_W-1:0]     wr_entry;
  logic [ENTRY_W-1:0]     rd_entry;

  // Arbitration: first requesting layer from the search start, wrapping.
  always_comb begin
    int unsigned cand;
    req     = s_axis_tvalid & cfg_layer_enable;
    arb_hit = 1'b0;
    arb_idx = '0;
    cand    = 0;
    for (int unsigned k = 0; k < LAYER_COUNT; k++) begin
      cand = cfg_fixed_priority ? k : (32'(rr_start) + k) % LAYER_COUNT;
      if (!arb_hit && req[IDX_W'(cand)]) begin
        arb_hit = 1'b1;
        arb_idx = IDX_W'(cand);
      end
    end
  end

  // Granted-layer input mux.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < LAYER_COUNT; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
        sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign full      = (count == PTR_W'(FIFO_DEPTH));
  assign fwd_acc   = (state == ST_FORWARD) && sel_valid && !full;
  assign drain_acc = (state == ST_DRAIN) && sel_valid;
  assign at_limit  = (beat_cnt == BEAT_W'(MAX_FRAME_BEATS - 1));
  assign trunc_c   = fwd_acc && !sel_last && at_limit;
  assign rd_en     = (count != '0) && m_axis_tready;

  // Only the granted layer sees ready; DRAIN swallows beats unconditionally.
  always_comb begin
    s_axis_tready = '0;
    for (int unsigned i = 0; i < LAYER_COUNT; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        if (state == ST_FORWARD) s_axis_tready[i] = !full;
        if (state == ST_DRAIN)   s_axis_tready[i] = 1'b1;
      end
    end
  end

  // FIFO write source: payload beat (tlast forced at the limit) or header.
  always_comb begin
    wr_en    = fwd_acc;
    wr_entry = {sel_last | at_limit, sel_data};
`ifdef LAYERS_FRAME_TAG_EN
    if ((state == ST_HEADER) && !full) begin
      wr_en    = 1'b1;
      wr_entry = {1'b0, DATA_WIDTH'(grant_idx) + DATA_WIDTH'(1)};
    end
`endif
  end

  // Frame FSM with registered grant and truncation pulse.
  always_ff @(posedge clk_core or negedge clk_core_resn) begin
    if (!clk_core_resn) begin
      state                <= ST_IDLE;
      grant_idx            <= '0;
      rr_start             <= '0;
      beat_cnt             <= '0;
      status_grant         <= '0;
      stat_frame_truncated <= 1'b0;
    end else begin
      stat_frame_truncated <= trunc_c;
      case (state)
        ST_IDLE: begin
          if (arb_hit) begin
            grant_idx    <= arb_idx;
            status_grant <= LAYER_COUNT'(1) << arb_idx;
            // Rotating at grant time keeps truncated frames fair as well.
            rr_start     <= (arb_idx == IDX_W'(LAYER_COUNT - 1)) ? '0 : arb_idx + IDX_W'(1);
            beat_cnt     <= '0;
`ifdef LAYERS_FRAME_TAG_EN
            state        <= ST_HEADER;
`else
            state        <= ST_FORWARD;
`endif
          end
        end
`ifdef LAYERS_FRAME_TAG_EN
        ST_HEADER: begin
          if (!full) state <= ST_FORWARD;
        end
`endif
        ST_FORWARD: begin
          if (fwd_acc) begin
            if (sel_last) begin
              state        <= ST_IDLE;
              status_grant <= '0;
            end else if (at_limit) begin
              state <= ST_DRAIN;
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (drain_acc && sel_last) begin
            state        <= ST_IDLE;
            status_grant <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_core or negedge clk_core_resn) begin
    if (!clk_core_resn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + PTR_W'(1);
        2'b01:   count <= count - PTR_W'(1);
        default: ;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_core) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

  // Masked when empty so outputs read zero out of reset.
  assign rd_entry      = (count != '0) ? mem[rd_ptr[AW-1:0]] : '0;
  assign m_axis_tdata  = rd_entry[DATA_WIDTH-1:0];
  assign m_axis_tlast  = rd_entry[DATA_WIDTH];
  assign m_axis_tvalid = (count != '0);
  assign data_count    = 32'(count);

endmodule

// File: tb/tb_layers_frame_arbiter_fifo.sv
// Scoreboard bench for layers_frame_arbiter_fifo: per-layer expected-beat
// queues filled at stimulus time, an independent monitor that pops on every
// output handshake, and an arbitration reference applied at each grant.
module tb_layers_frame_arbiter_fifo;

  localparam int unsigned N    = 5;
  localparam int unsigned DW   = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXB = 16;

  logic            clk;
  logic            rst_n;
  logic [N*DW-1:0] s_tdata;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tlast;
  logic [N-1:0]    s_tready;
  logic [N-1:0]    en;
  logic            fixed;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid;
  logic            m_tlast;
  logic            m_tready;
  logic [31:0]     data_count;
  logic [N-1:0]    status_grant;
  logic            trunc;

  layers_frame_arbiter_fifo #(
    .LAYER_COUNT(N), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MAX_FRAME_BEATS(MAXB)
  ) dut (
    .clk_core(clk), .clk_core_resn(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready), .cfg_layer_enable(en), .cfg_fixed_priority(fixed),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tready(m_tready), .data_count(data_count), .status_grant(status_grant),
    .stat_frame_truncated(trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_trunc = 0;
  int seen_trunc = 0;

  logic [DW:0] drv_q [N][$];   // beats still to be offered, {tlast, data}
  logic [DW:0] exp_q [N][$];   // beats expected at the output, per layer

  bit rand_ready = 0;
  bit fixed_ready = 1;
  bit gaps = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue one input frame and its expected output (truncated beyond MAXB).
  task automatic queue_frame(input int layer, input int len);
    logic [DW-1:0] d;
    logic [2:0] lid;
    lid = 3'(layer);
    for (int k = 0; k < len; k++) begin
      d = {lid, 5'($urandom)};
      drv_q[layer].push_back({(k == len - 1), d});
      if (k < int'(MAXB))
        exp_q[layer].push_back({(k == len - 1) || (k == int'(MAXB) - 1), d});
    end
    if (len > int'(MAXB)) exp_trunc++;
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < int'(N); i++)
      if (drv_q[i].size() != 0 || exp_q[i].size() != 0) return 0;
    return 1;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    int c;
    c = 0;
    while (!(all_empty() && data_count == 0 && status_grant == 0) && c < budget) begin
      @(posedge clk);
      c++;
    end
    chk({name, "_drain_timeout"}, 64'(c >= budget), 64'd0);
  endtask

  // Driver: advance on handshakes, hold valid until accepted.
  initial begin
    logic [N-1:0] hs;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b1;
    forever begin
      @(negedge clk);
      hs = s_tvalid & s_tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < int'(N); i++) begin
        if (hs[i] && drv_q[i].size() != 0) void'(drv_q[i].pop_front());
        if (drv_q[i].size() != 0 && ((s_tvalid[i] && !hs[i]) || !gaps || ($urandom % 3 != 0))) begin
          s_tvalid[i] = 1'b1;
          s_tlast[i]  = drv_q[i][0][DW];
          s_tdata[i*DW +: DW] = drv_q[i][0][DW-1:0];
        end else begin
          s_tvalid[i] = 1'b0;
          s_tlast[i]  = 1'b0;
        end
      end
      m_tready = rand_ready ? ($urandom % 4 != 0) : fixed_ready;
    end
  end

  // Reference arbitration rule.
  function automatic logic [N-1:0] arb_model(input logic [N-1:0] r, input logic fx, input int start);
    int idx;
    for (int k = 0; k < int'(N); k++) begin
      idx = fx ? k : (start + k) % int'(N);
      if (r[idx]) return N'(1) << idx;
    end
    return '0;
  endfunction

  // Monitor: grant rules, ready exclusivity, output scoreboard, hold stability.
  initial begin
    logic [N-1:0] prev_g, prev_req, eg;
    logic prev_fx, prev_mv, prev_mr, in_frame;
    logic [DW:0] prev_beat, beat, eb;
    int rr_next, cur;
    prev_g = '0; prev_req = '0; prev_fx = 0; prev_mv = 0; prev_mr = 0;
    in_frame = 0; rr_next = 0; cur = 0; prev_beat = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 0; rr_next = 0; prev_g = '0; prev_mv = 0; prev_mr = 0;
        prev_req = s_tvalid & en; prev_fx = fixed;
        continue;
      end
      if (prev_g == '0) begin
        eg = arb_model(prev_req, prev_fx, rr_next);
        chk("grant_decision", 64'(status_grant), 64'(eg));
        for (int i = 0; i < int'(N); i++) if (eg[i]) rr_next = (i + 1) % int'(N);
      end else if (status_grant != '0) begin
        chk("grant_held", 64'(status_grant), 64'(prev_g));
      end
      chk("ready_only_granted", 64'(s_tready & ~status_grant), 64'd0);
      if (trunc) seen_trunc++;
      beat = {m_tlast, m_tdata};
      if (prev_mv && !prev_mr) begin
        chk("out_valid_held", 64'(m_tvalid), 64'd1);
        chk("out_beat_held", 64'(beat), 64'(prev_beat));
      end
      if (m_tvalid && m_tready) begin
`ifdef LAYERS_FRAME_TAG_EN
        if (!in_frame) begin
          cur = int'(m_tdata) - 1;
          chk("header_tlast", 64'(m_tlast), 64'd0);
          chk("header_range", 64'(cur >= 0 && cur < int'(N)), 64'd1);
          if (cur < 0 || cur >= int'(N)) cur = 0;
          in_frame = 1;
        end else begin
`else
        begin
          if (!in_frame) begin
            cur = int'(m_tdata[DW-1:DW-3]);
            if (cur >= int'(N)) cur = 0;
            in_frame = 1;
          end
`endif
          if (exp_q[cur].size() == 0) begin
            chk("unexpected_beat", 64'(beat), 64'h1ff);
          end else begin
            eb = exp_q[cur].pop_front();
            chk("out_beat", 64'(beat), 64'(eb));
          end
          in_frame = !m_tlast;
        end
      end
      prev_g = status_grant; prev_req = s_tvalid & en; prev_fx = fixed;
      prev_mv = m_tvalid; prev_mr = m_tready; prev_beat = beat;
    end
  end

  initial begin
    int c;
    rst_n = 1'b0; en = '1; fixed = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_data_count", 64'(data_count), 64'd0);
    chk("rst_status_grant", 64'(status_grant), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_trunc", 64'(trunc), 64'd0);
    chk("rst_m_tdata", 64'({m_tlast, m_tdata}), 64'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Two 4-beat frames, round-robin from reset: layer 0 then layer 2.
    queue_frame(0, 4); queue_frame(2, 4);
    wait_drain("rr_pair", 500);
    chk("rr_pair_count", 64'(data_count), 64'd0);

    // Continuous requests from layers 1 and 3, fixed then round-robin.
    @(posedge clk); #2 fixed = 1'b1;
    for (int k = 0; k < 3; k++) begin queue_frame(1, 3); queue_frame(3, 3); end
    wait_drain("fixed_pri", 1000);
    @(posedge clk); #2 fixed = 1'b0;
    for (int k = 0; k < 3; k++) begin queue_frame(1, 3); queue_frame(3, 3); end
    wait_drain("round_robin", 1000);

    // Runaway frame: 20 beats, only the first MAXB survive; next frame intact.
    queue_frame(4, 20); queue_frame(4, 3);
    wait_drain("truncate", 1000);
    chk("trunc_pulses", 64'(seen_trunc), 64'(exp_trunc));

    // Backpressure: FIFO fills, granted ready drops, nothing lost on release.
    @(posedge clk); #2 fixed_ready = 0;
    queue_frame(0, 6);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("full_count", 64'(data_count), 64'(DEPTH));
    chk("full_ready_low", 64'(s_tready[0]), 64'd0);
    chk("full_valid", 64'(m_tvalid), 64'd1);
    @(posedge clk); #2 fixed_ready = 1;
    wait_drain("backpressure", 500);

    // Layer 0 disabled while requesting: never granted, never ready.
    @(posedge clk); #2 en = 5'b11110;
    queue_frame(0, 3); queue_frame(1, 3); queue_frame(1, 2);
    c = 0;
    while ((drv_q[1].size() != 0 || exp_q[1].size() != 0) && c < 500) begin
      @(posedge clk); c++;
    end
    chk("disable_l1_timeout", 64'(c >= 500), 64'd0);
    repeat (10) @(posedge clk);
    chk("disable_l0_pending", 64'(drv_q[0].size()), 64'd3);
    chk("disable_l0_no_output", 64'(exp_q[0].size()), 64'd3);
    @(posedge clk); #2 en = '1;
    wait_drain("disable", 500);

    // Randomized traffic: lengths 1..20, gaps, random downstream ready.
    rand_ready = 1; gaps = 1;
    for (int f = 0; f < 40; f++) begin
      if (f % 10 == 0) begin @(posedge clk); #2 fixed = 1'($urandom); end
      queue_frame(int'($urandom_range(N - 1, 0)), int'($urandom_range(20, 1)));
    end
    wait_drain("random", 20000);
    chk("random_trunc_pulses", 64'(seen_trunc), 64'(exp_trunc));
    rand_ready = 0; gaps = 0; fixed = 1'b0;

    // Reset mid-frame, then a fresh frame.
    @(posedge clk); #2 fixed_ready = 0;
    queue_frame(2, 10);
    c = 0;
    while (data_count < 2 && c < 200) begin @(posedge clk); c++; end
    chk("pre_reset_fill", 64'(c >= 200), 64'd0);
    @(posedge clk); #2 rst_n = 1'b0;
    for (int i = 0; i < int'(N); i++) begin drv_q[i].delete(); exp_q[i].delete(); end
    #1;
    chk("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("midrst_data_count", 64'(data_count), 64'd0);
    chk("midrst_grant", 64'(status_grant), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1; fixed_ready = 1;
    queue_frame(3, 3);
    wait_drain("post_reset", 500);
    chk("final_trunc_pulses", 64'(seen_trunc), 64'(exp_trunc));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/layers_frame_arbiter_fifo.md
Name: layers_frame_arbiter_fifo

Overview:
- Frame-granular arbiter plus output buffer for the per-layer MISO frame streams in the readout path; a parametrised successor to the switch-plus-fixed-FIFO merge stage.
- Merges LAYER_COUNT AXI-Stream inputs into one stream and never interleaves frames.
- Selectable round-robin or fixed-priority arbitration, per-layer enable, runaway-frame truncation, and a parametrised-depth FIFO with occupancy count for register-file readout.

Parameters:
- LAYER_COUNT, 5, number of input streams (1..16).
- DATA_WIDTH, 8, beat width in bits.
- FIFO_DEPTH, 1024, buffer entries; power of two, >= 4.
- MAX_FRAME_BEATS, 64, beats per frame before forced truncation (>= 2).

Ports:
- clk_core  in  1  core clock; all logic in this single domain.
- clk_core_resn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  LAYER_COUNT*DATA_WIDTH  per-layer data; layer i at [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tvalid  in  LAYER_COUNT  per-layer valid.
- s_axis_tlast  in  LAYER_COUNT  per-layer end of frame.
- s_axis_tready  out  LAYER_COUNT  per-layer ready.
- cfg_layer_enable  in  LAYER_COUNT  1 = layer may be granted.
- cfg_fixed_priority  in  1  0 = round-robin; 1 = lowest index wins.
- m_axis_tdata  out  DATA_WIDTH  buffered output data.
- m_axis_tvalid  out  1  FIFO not empty.
- m_axis_tlast  out  1  end of frame for the stored beat.
- m_axis_tready  in  1  downstream ready.
- data_count  out  32  FIFO occupancy, zero-extended.
- status_grant  out  LAYER_COUNT  one-hot current grant; 0 when idle.
- stat_frame_truncated  out  1  one-cycle pulse per truncation.

Behaviour:
- Reset values: all outputs 0. FIFO empties, FSM goes to IDLE, round-robin pointer points at layer 0.
- FSM states: IDLE, FORWARD, DRAIN.
- IDLE
  - Request vector = s_axis_tvalid & cfg_layer_enable.
  - If the request vector is nonzero, register the grant and go to FORWARD. This gives one bubble cycle between frames.
  - Round-robin: search starts at the index after the last granted layer and wraps modulo LAYER_COUNT.
  - Fixed priority: lowest set index wins.
  - s_axis_tready is 0 for all layers in IDLE.
- FORWARD
  - s_axis_tready[g] = FIFO not full; all other tready bits are 0.
  - Each accepted beat is written as {tlast, tdata}, and the beat counter increments.
  - Accepted beat with tlast=1: go to IDLE; the round-robin pointer moves to g.
  - Accepted beat number MAX_FRAME_BEATS with tlast=0:
    - The beat is stored with tlast forced to 1.
    - stat_frame_truncated pulses for one cycle.
    - FSM goes to DRAIN.
- DRAIN
  - s_axis_tready[g] = 1; incoming beats are discarded and not written.
  - The discarded beat with tlast=1 returns the FSM to IDLE.
- Clearing cfg_layer_enable[g] mid-frame does not abort the frame; enable is sampled only in IDLE.
- FIFO
  - Write when granted tvalid & tready; read when m_axis_tvalid & m_axis_tready.
  - First-word fall-through: a beat written at edge N is visible on m_axis at N+1.
  - Full is count == FIFO_DEPTH; no write while full, no read-to-write bypass.
  - Simultaneous read and write leaves the count unchanged.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
  - data_count updates on the same edge as the pointers.
- m_axis_tdata and m_axis_tlast are held stable while tvalid=1 and tready=0.
- Reset mid-frame discards the partial frame; downstream frame reassembly must tolerate this.

Optional Feature:
- Macro: LAYERS_FRAME_TAG_EN.
- Defined:
  - Adds state HEADER between IDLE and FORWARD.
  - HEADER writes one beat: data = grant index + 1, zero-extended to DATA_WIDTH; tlast=0.
  - If the FIFO is full, HEADER waits. s_axis_tready stays 0 during HEADER.
  - The header beat does not count toward MAX_FRAME_BEATS.
- Undefined: no HEADER state; output carries frame payload only.

Test Plan:
- Layers 0 and 2 each hold a 4-beat frame, round-robin, m_axis_tready=1 -> output is 4 beats of L0, then 4 of L2, one idle cycle between them, no interleaving; data_count returns to 0.
- Layers 1 and 3 request continuously with cfg_fixed_priority=1 -> only layer 1 is granted; with 0, grants alternate 1,3,1,3.
- 70-beat frame with no tlast, MAX_FRAME_BEATS=64 -> 64 beats stored, the 64th with tlast=1; one stat_frame_truncated pulse; beats 65..70 discarded; next frame unaffected.
- FIFO_DEPTH=4, m_axis_tready=0, 6-beat frame -> data_count reaches 4, granted tready drops; raising m_axis_tready yields all 6 beats in order with no loss.
- cfg_layer_enable=5'b11110 with layer 0 valid -> layer 0 is never granted, its tready stays 0, status_grant never sets bit 0.
- Assert clk_core_resn low mid-frame -> m_axis_tvalid=0 and data_count=0 immediately; after release, a fresh 3-beat frame passes correctly (with LAYERS_FRAME_TAG_EN: a header beat equal to layer+1 first).
